// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pcsrc encodings, NOP word and fetch state enum for the fetch stage
package pipe_pkg;
  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR = 2'b01;
  localparam logic [1:0] PCSRC_JR = 2'b10;
  localparam logic [1:0] PCSRC_J = 2'b11;
  localparam logic [31:0] NOP_INSN = 32'h0;
  typedef enum logic [1:0] {FETCH, WAIT, HOLD} fetch_state_e;
endpackage

// File: rtl/pipepc_reg.sv
// pipepc_reg: 32-bit enabled register, sync clear to RESET_PC (clk, clr, en_i, d_i -> q_o)
module pipepc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        en_i,
  input  logic [31:0] d_i,
  output logic [31:0] q_o
);
  always_ff @(posedge clk) q_o <= clr ? RESET_PC : en_i ? d_i : q_o;
endmodule

// File: rtl/pipeif_fetch.sv
// pipeif_fetch: PC owner issuing single-outstanding imem fetches and feeding IF/ID {pc4,ins,wir} with delay-slot redirects (ports: clk clr pcsrc bpc rpc jpc wpcir imem_* pc4 ins wir fetch_err; optional IMEM_TIMEOUT_EN)
module pipeif_fetch
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  input  logic        wpcir,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc4,
  output logic [31:0] ins,
  output logic        wir,
  output logic        fetch_err
);
  fetch_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, tgt_q, tgt_sel, buf_q, buf_d;
  logic redir_pend_q, redir_pend_d, ins_valid, accept, redir_now, to;
  pipepc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk(clk), .clr(clr), .en_i(accept), .d_i(pc_d), .q_o(pc_q)
  );
  pipepc_reg #(.RESET_PC(RESET_PC)) u_tgt (
    .clk(clk), .clr(clr), .en_i(redir_now & ~ins_valid), .d_i(tgt_sel), .q_o(tgt_q)
  );
  always_comb begin
    ins_valid = (state_q == WAIT & imem_rdy) | state_q == HOLD;
    accept = ins_valid & wpcir;
    redir_now = wpcir & (pcsrc != PCSRC_SEQ);
    tgt_sel = pcsrc == PCSRC_BR ? bpc : pcsrc == PCSRC_JR ? rpc : jpc;
    pc_d = redir_now ? tgt_sel : redir_pend_q ? tgt_q : pc_q + 32'd4;
    redir_pend_d = accept ? 1'b0 : redir_now ? 1'b1 : redir_pend_q;
    buf_d = (state_q == WAIT & imem_rdy & ~wpcir) ? imem_rdata : buf_q;
    state_d = state_q == FETCH ? WAIT : accept ? FETCH :
              (state_q == WAIT & imem_rdy) ? HOLD : to ? FETCH : state_q;
    imem_req = state_q == FETCH & ~clr;
    imem_addr = pc_q;
    pc4 = clr ? RESET_PC + 32'd4 : pc_q + 32'd4;
    ins = clr ? NOP_INSN : state_q == HOLD ? buf_q : ins_valid ? imem_rdata : NOP_INSN;
    wir = wpcir & ~clr;
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= FETCH;
      redir_pend_q <= 1'b0;
      buf_q <= NOP_INSN;
    end else begin
      state_q <= state_d;
      redir_pend_q <= redir_pend_d;
      buf_q <= buf_d;
    end
  end
`ifdef IMEM_TIMEOUT_EN
  logic [15:0] cnt_q;
  logic err_q;
  assign to = state_q == WAIT & ~imem_rdy & cnt_q == 16'(TIMEOUT - 1);
  assign fetch_err = err_q;
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= 16'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == WAIT & ~imem_rdy & ~to) ? cnt_q + 16'd1 : 16'd0;
      err_q <= err_q | to;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
  assign to = 1'b0;
  assign fetch_err = 1'b0;
`endif
endmodule

// File: doc/pipeif_fetch.md
Name: pipeif_fetch

Overview:
Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the PC and issues single-outstanding requests to a variable-latency instruction memory. Each cycle it delivers {pc4, ins, wir} to IF/ID, inserting a NOP bubble when no instruction is ready. It applies branch/jump redirects from ID with one-delay-slot semantics, latching a redirect that arrives while a fetch is still outstanding.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT, 16, max WAIT cycles before re-issue; used only with IMEM_TIMEOUT_EN

Ports:
clk  in  1  clock; all state updates on the rising edge
clr  in  1  synchronous active-high reset
pcsrc  in  2  next-PC select from ID: 00 seq, 01 bpc, 10 rpc, 11 jpc
bpc  in  32  branch target
rpc  in  32  jump-register target
jpc  in  32  jump target
wpcir  in  1  1 = ID accepts a new IF/ID value; 0 = stall
imem_req  out  1  fetch request, one-cycle pulse
imem_addr  out  32  fetch address (= pc)
imem_rdy  in  1  response valid for the outstanding request
imem_rdata  in  32  instruction word
pc4  out  32  pc+4 of the delivered instruction
ins  out  32  delivered instruction, or NOP (32'h0)
wir  out  1  IF/ID write enable
fetch_err  out  1  sticky timeout flag (only with IMEM_TIMEOUT_EN)

Behaviour:
- Reset (clr=1 at an edge): pc=RESET_PC, state=FETCH, redir_pend=0, buf_ins=0, fetch_err=0. While clr=1: imem_req=0, wir=0, ins=0, pc4=RESET_PC+4.
- States and transitions:
  - FETCH: imem_req=1, imem_addr=pc, then go to WAIT.
  - WAIT: stay in WAIT until imem_rdy=1.
  - HOLD: instruction received but ID stalled; buf_ins holds it.
- ins_valid = (WAIT & imem_rdy) | HOLD.
- ins: HOLD → buf_ins; WAIT & imem_rdy → imem_rdata (combinational, zero added latency); otherwise 0.
- pc4 = pc + 4, modulo 2^32.
- wir = wpcir in every non-reset cycle. A NOP is written when ins_valid=0.
- Accept = ins_valid & wpcir. On accept:
  - pc ← target per pcsrc if pcsrc≠00 this cycle; else latched target if redir_pend; else pc+4.
  - redir_pend ← 0; state ← FETCH.
- WAIT & imem_rdy & !wpcir: buf_ins ← imem_rdata, state ← HOLD.
- HOLD & wpcir: accept as above.
- Redirect without accept (pcsrc≠00 & wpcir=1 & ins_valid=0):
  - Latch the selected target and set redir_pend.
  - A later redirect before accept overwrites it (newest wins).
- pcsrc is ignored whenever wpcir=0, because ID is holding.
- Fetch latency ≥ 2 cycles from request to delivery (FETCH, then at least one WAIT cycle).
- imem_rdy outside WAIT is ignored.
- pc[1:0] is never forced; misaligned targets pass through unchanged.

Optional Feature:
Macro: IMEM_TIMEOUT_EN
- Defined:
  - A WAIT-cycle counter runs while in WAIT.
  - When the count reaches TIMEOUT with no imem_rdy, fetch_err is set (sticky until clr), the counter clears, and state returns to FETCH to re-issue the same pc.
  - A late response to the abandoned request is not distinguished.
- Undefined: no counter; fetch_err tied to 0; WAIT persists indefinitely.

Decomposition:
- Package pipe_pkg:
  - PCSRC_SEQ/BR/JR/J encodings
  - NOP_INSN = 32'h0
  - fetch state enum {FETCH, WAIT, HOLD}
- Sub-module pipepc_reg: 32-bit enabled register with synchronous active-high clear to RESET_PC, instanced for pc. The redirect latch reuses the same sub-module.

Test Plan:
- Reset, imem_rdy one cycle after every request, wpcir=1 → addresses 0,4,8…; each ins delivered with pc4=addr+4; wir=1 every cycle; NOP in FETCH cycles.
- WAIT+imem_rdy with wpcir=0 for 3 cycles, rdata=32'h2002_0005 → HOLD; wir=0 and ins stays 32'h2002_0005; accepted on the first wpcir=1 cycle, then next fetch at pc+4.
- pcsrc=01, bpc=32'h100 asserted while a fetch at 32'h8 has imem_rdy delayed 4 cycles → redir_pend set; delay-slot instruction at 32'h8 delivered; next imem_addr=32'h100.
- pcsrc=11, jpc=32'h40 on the same cycle as accept of the instruction at 32'hC → next imem_addr=32'h40; no latch used.
- clr asserted mid-WAIT → next cycle imem_req=0, wir=0, ins=0; after release first imem_addr=RESET_PC; the stale imem_rdy is ignored.
- IMEM_TIMEOUT_EN with TIMEOUT=16 and no imem_rdy → fetch_err=1 after 16 WAIT cycles; re-request at the same imem_addr; fetch_err stays 1 until clr.
